// File: rtl/face_result_uart_tx_if.sv
// Face-hit bus from the detection pipeline: one strobe per hit plus its fields.
interface face_result_uart_tx_if;
   logic        face_coords_ready;
   logic [7:0]  pyramid_number;
   logic [31:0] face_row;
   logic [31:0] face_col;
   logic [31:0] face_accum;

   modport master (
      output face_coords_ready, pyramid_number, face_row, face_col, face_accum
   );

   modport slave (
      input face_coords_ready, pyramid_number, face_row, face_col, face_accum
   );
endinterface

// File: rtl/face_result_uart_tx.sv
// Buffers face hits in a small FIFO and sends each one as a 13-byte 8N1 UART
// record: pyramid, col[4], row[4], accum[4], every field LSB byte first.
module face_result_uart_tx #(
   parameter int CLKS_PER_BIT = 54,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clock,
   input  logic                          reset_n,
   face_result_uart_tx_if.slave          hit,
   input  logic                          uart_cts,
   output logic                          uart_tx,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   drop_count,
   output logic                          busy
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] LAST_BYTE = 4'd12;

   typedef enum logic [2:0] {IDLE, POP, START, DATA, STOP} state_t;

   state_t             state, state_n;
   logic [BAUD_W-1:0]  baud_cnt, baud_n;
   logic [2:0]         bit_idx, bit_n;
   logic [3:0]         byte_idx, byte_n;
   logic [103:0]       shreg, shreg_n;
   logic               tx_n;

   logic [103:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [103:0]       record_in;
   logic               full, empty, pop, push, drop;

   assign record_in = {hit.face_accum, hit.face_row, hit.face_col, hit.pyramid_number};
   assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign empty     = (fifo_count == '0);
   assign pop       = (state == POP);
   // A pop in the same cycle frees a slot, so a hit arriving while full is still taken.
   assign push      = hit.face_coords_ready && (!full || pop);
   assign drop      = hit.face_coords_ready && full && !pop;
   assign busy      = (state != IDLE) || !empty;

   // Record storage; written on accepted hits.
   // NOTE: the storage array has no reset -- validity is tracked by the pointers
   // and count, so clearing it would only cost reset fan-out.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= record_in;
   end

   // FIFO pointers, occupancy and the saturating overflow counter.
   // NOTE: clocked state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         drop_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
         if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

   // Transmitter registers, including a registered (glitch-free) serial line.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= BAUD_RELOAD;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         uart_tx  <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         shreg    <= shreg_n;
         uart_tx  <= tx_n;
      end
   end

   // Next-state and datapath: baud counter reloads on every state entry; CTS is
   // looked at only in IDLE and at the end of a stop bit.
   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      shreg_n = shreg;
      unique case (state)
         IDLE: begin
            if (!empty && uart_cts) begin
               state_n = POP;
               baud_n  = BAUD_RELOAD;
            end
         end
         POP: begin
            shreg_n = mem[rd_ptr];
            byte_n  = '0;
            bit_n   = '0;
            baud_n  = BAUD_RELOAD;
            state_n = START;
         end
         START: begin
            if (baud_cnt == '0) begin
               bit_n   = '0;
               baud_n  = BAUD_RELOAD;
               state_n = DATA;
            end else begin
               baud_n = baud_cnt - BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_cnt == '0) begin
               shreg_n = shreg >> 1;
               baud_n  = BAUD_RELOAD;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 3'd1;
            end else begin
               baud_n = baud_cnt - BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_cnt == '0) begin
               if (byte_idx == LAST_BYTE) begin
                  state_n = IDLE;
                  baud_n  = BAUD_RELOAD;
               end else if (uart_cts) begin
                  byte_n  = byte_idx + 4'd1;
                  baud_n  = BAUD_RELOAD;
                  state_n = START;
               end
            end else begin
               baud_n = baud_cnt - BAUD_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      tx_n = 1'b1;
      if (state_n == START)     tx_n = 1'b0;
      else if (state_n == DATA) tx_n = shreg_n[0];
   end

endmodule

// File: tb/tb_face_result_uart_tx.sv
// Scoreboard bench: expected records are queued as hits are driven and compared
// against records decoded from the serial line.
module tb_face_result_uart_tx;

   localparam int CPB   = 54;
   localparam int DEPTH = 8;
   localparam int HALF  = CPB / 2;
   localparam longint REC_CYC = 130 * CPB;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        uart_cts;
   logic        uart_tx;
   logic [3:0]  fifo_count;
   logic [15:0] drop_count;
   logic        busy;

   face_result_uart_tx_if hit_if ();

   face_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .hit        (hit_if.slave),
      .uart_cts   (uart_cts),
      .uart_tx    (uart_tx),
      .fifo_count (fifo_count),
      .drop_count (drop_count),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   longint cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [103:0] pack(input logic [7:0] p, input logic [31:0] r,
                                         input logic [31:0] c, input logic [31:0] a);
      return {a, r, c, p};
   endfunction

   logic [103:0] sb [$];

   // ---------------- UART monitor ----------------
   bit           mon_active = 1'b0;
   int           mon_t;
   int           rec_bytes = 0;
   int           rec_count = 0;
   logic [7:0]   rx_byte;
   logic [103:0] rx_rec;
   logic [103:0] last_rec;
   longint       byte_start [13];
   longint       rec_t0 [16];

   always @(negedge clock) begin
      if (!reset_n) begin
         mon_active = 1'b0;
         rec_bytes  = 0;
      end else if (!mon_active) begin
         if (uart_tx === 1'b0) begin
            mon_active = 1'b1;
            mon_t      = 0;
            byte_start[rec_bytes] = cyc;
            if (rec_bytes == 0) rec_t0[rec_count] = cyc;
         end
      end else begin
         mon_t++;
         if (mon_t == HALF) begin
            check("start_bit", uart_tx, 1'b0);
         end else if (mon_t > HALF && mon_t < HALF + 9 * CPB && (mon_t - HALF) % CPB == 0) begin
            rx_byte = {uart_tx, rx_byte[7:1]};
         end else if (mon_t == HALF + 9 * CPB) begin
            check("stop_bit", uart_tx, 1'b1);
            rx_rec[8*rec_bytes +: 8] = rx_byte;
            mon_active = 1'b0;
            rec_bytes++;
            if (rec_bytes == 13) begin
               check("sb_nonempty", sb.size() > 0, 1'b1);
               if (sb.size() > 0) check($sformatf("record%0d", rec_count), rx_rec, sb.pop_front());
               last_rec = rx_rec;
               rec_count++;
               rec_bytes = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] exp_bytes [13] = '{8'h03, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00,
                                  8'h00, 8'h00, 8'h2C, 8'h01, 8'h00, 8'h00};

   // Call just after a clock edge; the hit is captured on the next edge and the
   // task returns #1 after that edge.
   task automatic drive_hit(input logic [7:0] p, input logic [31:0] r, input logic [31:0] c,
                            input logic [31:0] a, input bit accept);
      hit_if.face_coords_ready = 1'b1;
      hit_if.pyramid_number    = p;
      hit_if.face_row          = r;
      hit_if.face_col          = c;
      hit_if.face_accum        = a;
      if (accept) sb.push_back(pack(p, r, c, a));
      @(posedge clock); #1;
      hit_if.face_coords_ready = 1'b0;
   endtask

   longint b0, r_rise, t_hit;

   initial begin
      reset_n = 1'b0;
      uart_cts = 1'b1;
      hit_if.face_coords_ready = 1'b0;
      hit_if.pyramid_number = '0;
      hit_if.face_row = '0;
      hit_if.face_col = '0;
      hit_if.face_accum = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_tx", uart_tx, 1'b1);
      check("rst_fifo_count", fifo_count, 4'd0);
      check("rst_drop_count", drop_count, 16'd0);
      check("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Burst of 10 strobes: 9 accepted, the last one dropped.
      b0 = cyc + 1;
      for (int i = 0; i < 10; i++) begin
         drive_hit(8'(i), 32'h1000_0000 + 32'(i * 3), $urandom, $urandom, i < 9);
         if (i == 8) check("burst_peak_count", fifo_count, 4'd8);
      end
      check("burst_count_after", fifo_count, 4'd8);
      check("burst_drop", drop_count, 16'd1);
      check("burst_busy", busy, 1'b1);

      // Strobe exactly on the POP cycle of record 1 while the FIFO is full.
      while (cyc < b0 + 2 + REC_CYC + 1) begin
         @(posedge clock); #1;
      end
      drive_hit(8'hA5, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h8000_0001, 1'b1);
      check("fullpop_count", fifo_count, 4'd8);
      check("fullpop_drop", drop_count, 16'd1);

      // Saturation: FIFO still full and no pop pending for thousands of cycles.
      force dut.drop_count = 16'hFFFE;
      #1;
      release dut.drop_count;
      check("sat_preset", drop_count, 16'hFFFE);
      for (int i = 0; i < 3; i++) drive_hit(8'hEE, 32'd0, 32'd0, 32'd0, 1'b0);
      check("sat_drop", drop_count, 16'hFFFF);
      check("sat_count", fifo_count, 4'd8);

      // Flow control during byte 4 of record 1.
      for (int i = 0; i < 20000 && !(rec_count == 1 && rec_bytes == 4 && mon_active); i++)
         @(negedge clock);
      check("wait_byte4", rec_count == 1 && rec_bytes == 4 && mon_active, 1'b1);
      @(posedge clock); #1;
      uart_cts = 1'b0;
      repeat (1000) @(posedge clock);
      #1;
      check("cts_byte4_done", rec_bytes, 5);
      check("cts_line_high", uart_tx, 1'b1);
      check("cts_no_start", mon_active, 1'b0);
      uart_cts = 1'b1;
      r_rise = cyc;
      for (int i = 0; i < 100 && !(rec_bytes == 5 && mon_active); i++) @(negedge clock);
      check("wait_byte5", rec_bytes == 5 && mon_active, 1'b1);
      check("byte5_latency", byte_start[5] - r_rise, 1);
      check("rec_spacing", rec_t0[1] - rec_t0[0], REC_CYC + 2);
      check("first_latency", rec_t0[0] - b0, 2);
      check("fullpop_is_pop_edge", rec_t0[1], b0 + 2 + REC_CYC + 2);

      // Drain the nine burst records.
      for (int i = 0; i < 70000 && rec_count < 9; i++) @(negedge clock);
      check("burst_records", rec_count, 9);

      // Reset during byte 6 of the next record, with one more hit queued.
      for (int i = 0; i < 2000 && !(rec_bytes == 1 && mon_active); i++) @(negedge clock);
      check("wait_rec10_byte1", rec_bytes == 1 && mon_active, 1'b1);
      @(posedge clock); #1;
      drive_hit(8'h77, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b1);
      check("extra_count", fifo_count, 4'd1);
      for (int i = 0; i < 4000 && !(rec_bytes == 6 && mon_active); i++) @(negedge clock);
      check("wait_byte6", rec_bytes == 6 && mon_active, 1'b1);
      @(negedge clock); #2;
      check("pre_reset_tx", uart_tx, 1'b0);
      reset_n = 1'b0;
      #1;
      check("async_rst_tx", uart_tx, 1'b1);
      check("async_rst_count", fifo_count, 4'd0);
      check("async_rst_drop", drop_count, 16'd0);
      check("async_rst_busy", busy, 1'b0);
      sb.delete();
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Single hit after reset, against the documented byte sequence.
      t_hit = cyc + 1;
      drive_hit(8'd3, 32'd17, 32'd42, 32'h0000_012C, 1'b1);
      for (int i = 0; i < 8000 && rec_count < 10; i++) @(negedge clock);
      check("single_done", rec_count, 10);
      check("single_latency", rec_t0[9] - t_hit, 2);
      check("single_duration", byte_start[12] - byte_start[0], 12 * 10 * CPB);
      for (int i = 0; i < 13; i++)
         check($sformatf("single_byte%0d", i), last_rec[8*i +: 8], exp_bytes[i]);
      repeat (40) @(posedge clock);
      #1;
      check("idle_busy", busy, 1'b0);
      check("idle_tx", uart_tx, 1'b1);
      check("idle_count", fifo_count, 4'd0);
      check("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/face_result_uart_tx.md
# face_result_uart_tx

Downstream of the Viola-Jones detection pipeline. Captures each face hit (pyramid level, row, column, accumulator) into a small FIFO and serializes every hit as a 13-byte record on the board UART transmit line (8N1, LSB first). Hits arrive in bursts faster than the UART can drain them, so records are buffered; overflow drops the newest hit and is counted. Host-side tooling decodes the 13-byte record unchanged.

## Interface

- CLKS_PER_BIT, 54: clock cycles per UART bit.
- FIFO_DEPTH, 8: records buffered; power of two, ≥2.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- face_coords_ready  in  1  one-cycle strobe per hit; may be high on consecutive cycles.
- pyramid_number  in  8  pyramid level of hit.
- face_row  in  32  row of hit.
- face_col  in  32  column of hit.
- face_accum  in  32  stage accumulator value; treated as raw bits.
- uart_cts  in  1  high = host permits transmission.
- uart_tx  out  1  serial line; idles high.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  records currently buffered.
- drop_count  out  16  hits lost to overflow; saturates at 16'hFFFF.
- busy  out  1  high while a record is being shifted out or FIFO non-empty.

## Operation

- Record: 104 bits {accum[31:0], row[31:0], col[31:0], pyramid[7:0]}. Byte 0 = pyramid, bytes 1-4 = col, bytes 5-8 = row, bytes 9-12 = accum. Each multi-byte field is sent LSB byte first; each byte is sent LSB bit first.
- Push: face_coords_ready high and FIFO not full writes the record at the clock edge.
- Overflow: face_coords_ready high while full and no pop in that cycle drops the hit and increments drop_count, saturating.
- Full with simultaneous pop: the push is accepted and the count is unchanged.
- FSM states: IDLE, POP, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty and uart_cts is high, go to POP.
  - POP: dequeue the record into the 104-bit shift register, set byte index to 0, go to START.
  - START: uart_tx = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: uart_tx = 1 for CLKS_PER_BIT cycles. If the byte index is 12, go to IDLE. Otherwise increment the index and return to START; if uart_cts is low, hold in STOP (line high) until it rises.
- uart_cts is sampled only at byte boundaries. Deassertion mid-byte completes the current byte.
- The baud counter is a down-counter reloaded on every state entry. It is at least $clog2(CLKS_PER_BIT) bits wide.
- Reset (asynchronous, any state): FSM to IDLE, uart_tx = 1, FIFO emptied (pointers 0), fifo_count = 0, drop_count = 0, busy = 0. A partially sent record is abandoned, and the host resynchronizes on its own.

## Timing

- Hit strobe at edge N is written at edge N. IDLE detects non-empty at edge N+1 and enters POP. POP at N+2 enters START, so uart_tx falls 2 cycles after the write edge.
- One byte = 10·CLKS_PER_BIT cycles. One record with uart_cts held high = 130·CLKS_PER_BIT cycles, with no gaps between bytes.
- Back-to-back records have 2 idle-high cycles (IDLE, POP) between the last stop bit and the next start bit.
- fifo_count updates on the same edge as push or pop.
- busy is combinational from FSM state and fifo_count.

## Test plan

- Single hit: pyramid=3, row=17, col=42, accum=0x0000012C, with uart_cts=1. The decoded bytes must be 03 2A 00 00 00 11 00 00 00 2C 01 00 00. The start bit must fall 2 cycles after the strobe, and the record must take 130·54 cycles.
- Burst: 10 consecutive strobes with FIFO_DEPTH=8 and none drained in between. Cycle 0 write; cycle 1 IDLE→POP; cycle 2 pop, so from cycle 2 push and pop cancel. Hits 0-7 written on cycles 0-7 with hit 0 popped on cycle 2; hit 8 accepted on cycle 8; hit 9 on cycle 9 arrives full with no pop and is dropped. Required: drop_count=1, fifo_count peaks at 8, and 9 records are received in order.
- Full with simultaneous pop: a strobe lands on the POP cycle while the FIFO is full. The hit must be accepted and drop_count must stay unchanged.
- Flow control: uart_cts dropped during byte 4 of a record. Byte 4 must complete, and the line must stay high in STOP. When uart_cts rises 1000 cycles later, byte 5 must start 1 cycle after the rise and the record must decode correctly.
- Reset mid-record: reset_n asserted during byte 6. uart_tx must go 1 asynchronously, and fifo_count and drop_count must read 0. A new hit after release must produce a correct 13-byte record.
- drop_count saturation: force drop_count to 16'hFFFE, then cause 3 overflows. drop_count must read 16'hFFFF.
